// File: rtl/cnn_layer_accel_octo_datain_parser_pkg.sv
// Shared definitions for the octo datain parser: header type codes,
// header field positions, length width default and parser state encodings.
package cnn_layer_accel_octo_datain_parser_pkg;

  localparam logic [1:0] HDR_ILLEGAL   = 2'b00;
  localparam logic [1:0] HDR_SEQ       = 2'b01;
  localparam logic [1:0] HDR_PIXEL     = 2'b10;
  localparam logic [1:0] HDR_MAP_START = 2'b11;

  localparam int HDR_TYPE_LSB    = 0;
  localparam int HDR_TYPE_W      = 2;
  localparam int HDR_LEN_LSB     = 8;
  localparam int C_LEN_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_HDR     = 2'b01,
    ST_PAYLOAD = 2'b10
  } state_e;

  function automatic int seq_cnt_w(input int depth);
    return $clog2((depth / 2) * 5) + 1;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_octo_datain_oreg.sv
// One-entry output register for the datain bus: holds word and type tag
// until the matching rdy accepts it.
module cnn_layer_accel_octo_datain_oreg #(
  parameter int C_DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [C_DATA_WIDTH-1:0] load_data,
  input  logic                    load_pixel,
  input  logic                    seq_rdy,
  input  logic                    pixel_rdy,
  output logic                    valid,
  output logic [C_DATA_WIDTH-1:0] data,
  output logic                    seq_tag,
  output logic                    pixel_tag,
  output logic                    xfer
);

  logic                    valid_q, valid_d;
  logic [C_DATA_WIDTH-1:0] data_q, data_d;
  logic                    pixel_q, pixel_d;

  always_comb begin
    xfer    = valid_q && (pixel_q ? pixel_rdy : seq_rdy);
    valid_d = valid_q;
    data_d  = data_q;
    pixel_d = pixel_q;
    if (xfer) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      pixel_d = load_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pixel_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pixel_q <= pixel_d;
    end
  end

  assign valid     = valid_q;
  assign data      = data_q;
  assign seq_tag   = valid_q && !pixel_q;
  assign pixel_tag = valid_q && pixel_q;

endmodule

// File: rtl/cnn_layer_accel_octo_datain_parser.sv
// Packet parser feeding the octo BRAM controller from an FWFT FIFO.
// Optional stall counter: define CNN_LAYER_ACCEL_DATAIN_STALL_CNT_EN.
module cnn_layer_accel_octo_datain_parser
  import cnn_layer_accel_octo_datain_parser_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 64,
  parameter int C_BRAM_DEPTH  = 1024,
  parameter int C_LEN_WIDTH   = C_LEN_WIDTH_DEF,
  localparam int C_SEQ_CNT_W  = seq_cnt_w(C_BRAM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [C_DATA_WIDTH-1:0] fifo_dout,
  output logic                    fifo_rd_en,
  output logic [C_DATA_WIDTH-1:0] datain,
  output logic                    datain_valid,
  output logic                    seq_datain_tag,
  output logic                    pixel_datain_tag,
  input  logic                    seq_datain_rdy,
  input  logic                    pixel_datain_rdy,
  output logic                    new_map,
  output logic [C_SEQ_CNT_W-1:0]  seq_count,
  output logic [17:0]             pixel_count,
  output logic                    hdr_err,
  output logic                    busy,
  output logic [31:0]             stall_cycles
);

  localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = 1;
  localparam logic [C_SEQ_CNT_W-1:0] SEQ_ONE = 1;
  localparam logic [17:0]            PIX_ONE = 1;

  state_e                   state_q, state_d;
  logic [C_LEN_WIDTH-1:0]   len_q, len_d;
  logic [C_LEN_WIDTH-1:0]   fetched_q, fetched_d;
  logic [C_LEN_WIDTH-1:0]   sent_q, sent_d;
  logic                     pixel_q, pixel_d;
  logic                     new_map_q, new_map_d;
  logic                     hdr_err_q, hdr_err_d;
  logic [C_SEQ_CNT_W-1:0]   seq_count_q, seq_count_d;
  logic [17:0]              pixel_count_q, pixel_count_d;

  logic                     rd_en;
  logic                     load;
  logic                     xfer;
  logic [HDR_TYPE_W-1:0]    hdr_type;
  logic [C_LEN_WIDTH-1:0]   hdr_len;

  assign hdr_type = fifo_dout[HDR_TYPE_LSB +: HDR_TYPE_W];
  assign hdr_len  = fifo_dout[HDR_LEN_LSB +: C_LEN_WIDTH];

  cnn_layer_accel_octo_datain_oreg #(
    .C_DATA_WIDTH(C_DATA_WIDTH)
  ) u_oreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (fifo_dout),
    .load_pixel(pixel_q),
    .seq_rdy   (seq_datain_rdy),
    .pixel_rdy (pixel_datain_rdy),
    .valid     (datain_valid),
    .data      (datain),
    .seq_tag   (seq_datain_tag),
    .pixel_tag (pixel_datain_tag),
    .xfer      (xfer)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    fetched_d = fetched_q;
    sent_d    = sent_q;
    pixel_d   = pixel_q;
    new_map_d = 1'b0;
    hdr_err_d = 1'b0;
    rd_en     = 1'b0;
    load      = 1'b0;
    unique case (1'b1)
      (state_q == ST_HDR): begin
        if (!fifo_empty && !rst) begin
          rd_en = 1'b1;
          unique case (hdr_type)
            HDR_MAP_START: new_map_d = 1'b1;
            HDR_SEQ, HDR_PIXEL: begin
              if (hdr_len != '0) begin
                len_d     = hdr_len;
                pixel_d   = (hdr_type == HDR_PIXEL);
                fetched_d = '0;
                sent_d    = '0;
                state_d   = ST_PAYLOAD;
              end
            end
            default: hdr_err_d = 1'b1;
          endcase
        end
      end
      (state_q == ST_PAYLOAD): begin
        load = (!datain_valid || xfer) && !fifo_empty
            && (fetched_q < len_q) && !rst;
        rd_en = load;
        if (load) fetched_d = fetched_q + LEN_ONE;
        if (xfer) sent_d = sent_q + LEN_ONE;
        // last word accepted: the next header waits one cycle
        if (xfer && (sent_q + LEN_ONE == len_q)) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_comb begin
    seq_count_d   = seq_count_q;
    pixel_count_d = pixel_count_q;
    if (new_map_d) begin
      seq_count_d   = '0;
      pixel_count_d = '0;
    end else if (xfer) begin
      if (seq_datain_tag && !(&seq_count_q))
        seq_count_d = seq_count_q + SEQ_ONE;
      if (pixel_datain_tag && !(&pixel_count_q))
        pixel_count_d = pixel_count_q + PIX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HDR;
      len_q         <= '0;
      fetched_q     <= '0;
      sent_q        <= '0;
      pixel_q       <= 1'b0;
      new_map_q     <= 1'b0;
      hdr_err_q     <= 1'b0;
      seq_count_q   <= '0;
      pixel_count_q <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      fetched_q     <= fetched_d;
      sent_q        <= sent_d;
      pixel_q       <= pixel_d;
      new_map_q     <= new_map_d;
      hdr_err_q     <= hdr_err_d;
      seq_count_q   <= seq_count_d;
      pixel_count_q <= pixel_count_d;
    end
  end

`ifdef CNN_LAYER_ACCEL_DATAIN_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (new_map_d) stall_d = '0;
    else if (datain_valid && !xfer && !(&stall_q))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign fifo_rd_en  = rd_en && !rst;
  assign new_map     = new_map_q;
  assign hdr_err     = hdr_err_q;
  assign seq_count   = seq_count_q;
  assign pixel_count = pixel_count_q;
  assign busy        = (state_q != ST_HDR) || datain_valid;

endmodule
